// File: rtl/ct_pt_add_seq_pkg.sv
// Shared types and default configuration for the sequential ciphertext-plaintext adder.
// Ciphertexts are (A, B) pairs of N coefficient words; plaintexts are N words.
package ct_pt_add_seq_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;
  localparam int Q_MOD_L   = 97;
  localparam int DELTA_L   = 10;

  typedef logic [W_BITS_L-1:0] word_t;
  typedef word_t [N_SLOTS_L-1:0] PT_t;

  typedef struct packed {
    PT_t a;
    PT_t b;
  } CT_t;

endpackage

// File: rtl/ct_pt_add_lane.sv
// One shared datapath lane: r = (signed(b) + DELTA*signed(gamma)) mod q, always in [0, q).
// Result is registered, giving one cycle of latency.
module ct_pt_add_lane #(
  parameter int W      = 16,
  parameter int WW     = 32,
  parameter int QP     = 97,
  parameter int DELTAP = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] b,
  input  logic [W-1:0] gamma,
  output logic [W-1:0] r
);

  localparam logic signed [WW-1:0] Q_S     = WW'(QP);
  localparam logic signed [WW-1:0] DELTA_S = WW'(DELTAP);

  logic signed [WW-1:0] b_ext;
  logic signed [WW-1:0] g_ext;
  logic signed [WW-1:0] sum;
  logic signed [WW-1:0] rem;
  logic signed [WW-1:0] res;

  always_comb begin
    b_ext = {{(WW-W){b[W-1]}}, b};
    g_ext = {{(WW-W){gamma[W-1]}}, gamma};
    sum   = b_ext + DELTA_S * g_ext;
    // Signed % keeps the dividend's sign, so fold negative remainders back into [0, q).
    rem   = sum % Q_S;
    res   = (rem < 0) ? rem + Q_S : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
    end else begin
      r <= W'(res);
    end
  end

endmodule

// File: rtl/ct_pt_add_seq.sv
// Sequential ciphertext-plaintext add: B' = (B + DELTA*GAMMA) mod q, A passed through.
// LANES shared lanes sweep the N slots chunk by chunk under a small FSM.
module ct_pt_add_seq
  import ct_pt_add_seq_pkg::*;
#(
  parameter int N      = N_SLOTS_L,
  parameter int W      = W_BITS_L,
  parameter int WW     = 2*W_BITS_L,
  parameter int LANES  = 2,
  parameter int QP     = Q_MOD_L,
  parameter int DELTAP = DELTA_L
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  CT_t  in_ct,
  input  PT_t  in_gamma,
  output logic out_valid,
  input  logic out_ready,
  output CT_t  out_ct,
  output logic busy
);

  localparam int CHUNKS = N / LANES;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int SLOT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CHUNKS-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  if (N % LANES != 0) begin : g_bad_lanes
    $fatal(1, "ct_pt_add_seq: N (%0d) must be a multiple of LANES (%0d)", N, LANES);
  end
  if (N != N_SLOTS_L || W != W_BITS_L) begin : g_bad_types
    $fatal(1, "ct_pt_add_seq: N/W must match the package word and vector types");
  end
  if (1) begin : g_info
    $info("ct_pt_add_seq: q=%0d delta=%0d N=%0d LANES=%0d", QP, DELTAP, N, LANES);
  end

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] wr_chunk;
  logic             wr_en;
  logic             accept;
  PT_t              b_buf;
  PT_t              g_buf;
  CT_t              out_ct_reg;
  logic             out_valid_reg;
  word_t            lane_r [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SLOT_W-1:0] rd_slot;
    assign rd_slot = SLOT_W'(int'(idx_reg) * LANES + gi);

    ct_pt_add_lane #(
      .W      (W),
      .WW     (WW),
      .QP     (QP),
      .DELTAP (DELTAP)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .b     (b_buf[rd_slot]),
      .gamma (g_buf[rd_slot]),
      .r     (lane_r[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (idx_reg == LAST) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == IDLE);
    busy     = (state_reg != IDLE);
    accept   = in_valid && in_ready;
    // Lanes lag the issue index by one cycle, so RUN writes back the previous chunk.
    wr_en    = ((state_reg == RUN) && (idx_reg != '0)) || (state_reg == DRAIN);
    wr_chunk = (state_reg == RUN) ? idx_reg - 1'b1 : LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg       <= '0;
      b_buf         <= '0;
      g_buf         <= '0;
      out_ct_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            b_buf        <= in_ct.b;
            g_buf        <= in_gamma;
            out_ct_reg.a <= in_ct.a;
            idx_reg      <= '0;
          end
        end
        RUN: begin
          if (idx_reg != LAST) idx_reg <= idx_reg + 1'b1;
        end
        DRAIN: out_valid_reg <= 1'b1;
        DONE: begin
          if (out_ready) out_valid_reg <= 1'b0;
        end
        default: ;
      endcase
      if (wr_en) begin
        for (int j = 0; j < LANES; j++) begin
          out_ct_reg.b[SLOT_W'(int'(wr_chunk) * LANES + j)] <= lane_r[j];
        end
      end
    end
  end

  assign out_ct    = out_ct_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_ct_pt_add_seq.sv
// Scoreboard bench for ct_pt_add_seq (N=8, LANES=2, q=97, delta=10): stimulus pushes
// expected ciphertexts, an independent monitor pops and compares on each output handshake.
module tb_ct_pt_add_seq;
  import ct_pt_add_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  CT_t  in_ct;
  PT_t  in_gamma;
  logic out_valid;
  logic out_ready;
  CT_t  out_ct;
  logic busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_res    = 0;
  int   cyc      = 0;
  CT_t  exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ct_pt_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_gamma  (in_gamma),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic PT_t fill(input word_t v);
    PT_t p;
    for (int i = 0; i < N_SLOTS_L; i++) p[i] = v;
    return p;
  endfunction

  function automatic PT_t mk_a(input int seed);
    PT_t p;
    for (int i = 0; i < N_SLOTS_L; i++) p[i] = word_t'(seed * 256 + i * 3 + 1);
    return p;
  endfunction

  // Golden slot model for q=97, delta=10 with signed 16-bit operands.
  function automatic word_t model(input word_t b, input word_t g);
    int s;
    s = int'($signed(b)) + 10 * int'($signed(g));
    s = s % 97;
    if (s < 0) s += 97;
    return word_t'(s);
  endfunction

  // Monitor: compare each delivered result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got a result, expected none pending");
      end else begin
        CT_t e;
        e = exp_q.pop_front();
        n_res++;
        for (int i = 0; i < N_SLOTS_L; i++) begin
          check($sformatf("res%0d_a[%0d]", n_res, i), 64'(out_ct.a[i]), 64'(e.a[i]));
          check($sformatf("res%0d_b[%0d]", n_res, i), 64'(out_ct.b[i]), 64'(e.b[i]));
        end
        $display("result %0d compared at cycle %0d", n_res, cyc);
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("wait_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  // Called and returns at 1 ns after a rising edge.
  task automatic issue(input PT_t a, input PT_t b, input PT_t g, input PT_t exp_b, input bit push);
    CT_t e;
    wait_ready();
    in_ct.a  = a;
    in_ct.b  = b;
    in_gamma = g;
    in_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      e.a = a;
      e.b = exp_b;
      exp_q.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((!in_ready || out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("wait_idle_timeout", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PT_t  b_v, g_v, e_v;
    CT_t  snap;
    int   lat;
    int   acc [3];

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_ct     = '0;
    in_gamma  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_ct_zero", 64'(out_ct == '0), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // 1. Basic: (90 + 10) mod 97 = 3, latency CHUNKS+1 = 5 edges
    issue(mk_a(1), fill(16'd90), fill(16'd1), fill(16'd3), 1'b1);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 50);
    check("latency", 64'(lat), 64'd5);
    wait_idle();

    // 2. Signed wrap: 5 - 10 = -5 -> 92
    issue(mk_a(2), fill(16'd5), fill(16'hFFFF), fill(16'd92), 1'b1);
    wait_idle();
    for (int i = 0; i < N_SLOTS_L; i++) begin
      b_v[i] = word_t'(i);
      g_v[i] = word_t'(i);
      e_v[i] = model(b_v[i], g_v[i]);
    end
    issue(mk_a(3), b_v, g_v, e_v, 1'b1);
    wait_idle();

    // 3. Backpressure for 20 cycles with a competing request held on the input
    out_ready = 1'b0;
    issue(mk_a(4), fill(16'd96), fill(16'd2), fill(16'd19), 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_out_valid_rise", 64'(out_valid), 64'd1);
    snap     = out_ct;
    in_ct.a  = mk_a(9);
    in_ct.b  = fill(16'd7);
    in_gamma = fill(16'd7);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid_%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold_ct_%0d", k), 64'(out_ct === snap), 64'd1);
      check($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);

    // 4. Back-to-back: in_valid and out_ready held high, accepts every CHUNKS+3 = 7 cycles
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      CT_t e;
      for (int i = 0; i < N_SLOTS_L; i++) begin
        b_v[i] = word_t'(20 * k + i);
        g_v[i] = word_t'(k + 3);
      end
      e.a = mk_a(10 + k);
      for (int i = 0; i < N_SLOTS_L; i++) e.b[i] = model(b_v[i], g_v[i]);
      in_ct.a  = e.a;
      in_ct.b  = b_v;
      in_gamma = g_v;
      wait_ready();
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      acc[k] = cyc;
    end
    in_valid = 1'b0;
    check("b2b_period_1", 64'(acc[1] - acc[0]), 64'd7);
    check("b2b_period_2", 64'(acc[2] - acc[1]), 64'd7);
    wait_idle();

    // 5. Asynchronous reset two cycles into RUN; the aborted request must never appear
    issue(mk_a(20), fill(16'd50), fill(16'd3), fill(16'd80), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_out_ct_zero", 64'(out_ct == '0), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    issue(mk_a(21), fill(16'd1), fill(16'd2), fill(16'd21), 1'b1);
    wait_idle();

    // 6. One-hot gamma at the last slot: only B'[7] = 10
    g_v = '0;
    g_v[7] = 16'd1;
    e_v = '0;
    e_v[7] = 16'd10;
    issue(mk_a(30), '0, g_v, e_v, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("results_delivered", 64'(n_res), 64'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
